// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and the MEM stage,
// data first, with a streak limit so fetch still makes progress under sustained data traffic.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LAT  = 2,
    parameter int MAXD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_sel,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] LAT_C  = 4'(LAT);
    localparam logic [3:0] MAXD_C = 4'(MAXD);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n, streak, streak_n;
    logic sel_n, en_n, we_n, if_done_n, d_done_n, d_win;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n;
    assign d_win    = d_req & ~(if_req & (streak == MAXD_C));
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;
    assign if_rdata = if_done ? mem_rdata : '0;
    assign d_rdata  = (d_done & ~mem_we) ? mem_rdata : '0;
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        streak_n  = streak;
        sel_n     = mem_sel;
        we_n      = mem_we;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        en_n      = 1'b0;
        if_done_n = 1'b0;
        d_done_n  = 1'b0;
        if (state == IDLE) begin
            if (if_req | d_req) begin
                state_n  = BUSY;
                cnt_n    = 4'd1;
                en_n     = 1'b1;
                sel_n    = d_win;
                we_n     = d_win & d_we;
                addr_n   = d_win ? d_addr : if_addr;
                wdata_n  = d_win ? d_wdata : '0;
                streak_n = (d_win & if_req) ? ((streak < MAXD_C) ? streak + 4'd1 : streak) : 4'd0;
            end
        end else begin
            cnt_n = cnt + 4'd1;
            // the done cycle still counts as busy so the owner's held request is not re-granted
            if (if_done | d_done)
                state_n = IDLE;
            else if (cnt == LAT_C) begin
                d_done_n  = mem_sel;
                if_done_n = ~mem_sel;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            mem_sel   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            streak    <= streak_n;
            mem_sel   <= sel_n;
            mem_en    <= en_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            if_done   <= if_done_n;
            d_done    <= d_done_n;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the MIPS core between the instruction-fetch stage and the data-memory (MEM) stage. It arbitrates the two requesters, sequences each transaction over a fixed-latency memory, and drives the select of the 2:1 address/data mux in front of the port. It returns read data and a one-cycle completion pulse to the granted requester, and stalls the other requester. A starvation guard keeps instruction fetch progressing under sustained data traffic.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory read latency in cycles from issue to valid `mem_rdata`; legal range 1..15
- MAXD, 2, maximum consecutive data grants while fetch is pending; legal range 1..7

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request, held until `if_done`
- if_addr  in  AW  fetch address
- if_done  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DW  fetch read data; valid only while `if_done`=1, else 0
- if_stall  out  1  `if_req & ~if_done`
- d_req  in  1  data request, held until `d_done`
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_done  out  1  one-cycle completion pulse to data stage
- d_rdata  out  DW  data read data; valid only while `d_done`=1 and it was a read, else 0
- d_stall  out  1  `d_req & ~d_done`
- mem_sel  out  1  mux select: 1 = data path, 0 = fetch path
- mem_en  out  1  one-cycle issue strobe
- mem_we  out  1  write enable, qualified by `mem_en`
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after `mem_en`

## Operation
- States: IDLE, BUSY.
- IDLE, no request: outputs hold, `mem_en`=0, stay IDLE.
- IDLE, any request: arbitrate and register the owner, `mem_sel`, `mem_addr`, `mem_we` and `mem_wdata`. Set `mem_en`=1 and `cnt`=1, then go to BUSY.
  - `mem_we` = `d_we` for a data grant, 0 for a fetch grant.
  - `mem_wdata` = `d_wdata` for a data grant, 0 for a fetch grant.
- Arbitration priority: data wins over fetch, except when `streak`==MAXD and `if_req`=1, in which case fetch wins.
- `streak` update:
  - Increments on each data grant made while `if_req`=1.
  - Clears on any fetch grant.
  - Clears on a data grant made while `if_req`=0.
  - Saturates at MAXD.
- BUSY:
  - `mem_en`=0 after the first BUSY cycle.
  - `mem_sel`, `mem_addr`, `mem_we` and `mem_wdata` are held stable for the whole transaction.
  - `cnt` increments each cycle.
  - When `cnt`==LAT: pulse the owner's done, pass `mem_rdata` to the owner's rdata (0 for writes), and go to IDLE.
- The non-owner's request is ignored during BUSY and is arbitrated in the next IDLE cycle.
- If the owner drops its request mid-transaction, the transaction still completes and the done pulse is still emitted.
- Widths: `cnt` and `streak` are 4 bits. No address arithmetic is performed; addresses pass through unchanged.

## Timing
- Reset (synchronous):
  - State becomes IDLE; `cnt`=0 and `streak`=0.
  - `mem_en`, `mem_we`, `mem_sel`, `mem_addr`, `mem_wdata`, `if_done`, `d_done`, `if_rdata` and `d_rdata` are all 0.
  - Any in-flight transaction is discarded and no done pulse is produced.
- Transaction timeline, with the request first seen in IDLE at cycle 0:
  - Cycle 1: issue, `mem_en`=1.
  - Cycle 1+LAT: done pulse.
  - Cycle 2+LAT: IDLE again.
- Latency is LAT+1 cycles from request to done. Throughput is one transaction per LAT+2 cycles.
- Handshake: the requester drops or changes its request at the clock edge ending its done cycle. A request that is high in IDLE is always treated as a new request.
- `if_stall` and `d_stall` are combinational from the request inputs and the registered done outputs.
- Simultaneous requests in IDLE are resolved by the priority and `streak` rules above. Only one grant is issued per IDLE cycle.

## Test plan
- Single fetch, LAT=2:
  - Stimulus: `if_req`=1 with `if_addr`=0x00400000 at cycle 0, memory returns 0x8C080004.
  - Cycle 1: `mem_en`=1, `mem_sel`=0, `mem_addr`=0x00400000.
  - Cycle 3: `if_done`=1 and `if_rdata`=0x8C080004. `if_stall`=1 in cycles 0–2.
- Data write:
  - Stimulus: `d_req`=1, `d_we`=1, `d_addr`=0x10010000, `d_wdata`=0xDEADBEEF at cycle 0.
  - Cycle 1: `mem_en`=1, `mem_we`=1, `mem_sel`=1.
  - Cycle 3: `d_done`=1 and `d_rdata`=0.
- Simultaneous requests at cycle 0:
  - Data is served first: issue at cycle 1, `d_done` at cycle 3.
  - Fetch is served next: issue at cycle 5, `if_done` at cycle 7.
  - `if_stall` stays high from cycle 0 through cycle 6.
- Starvation guard, MAXD=2:
  - Stimulus: both requests held continuously, each re-raised after its done.
  - Required grant order: D, D, I, D, D, I.
- Reset mid-transaction:
  - Stimulus: `rst`=1 at cycle 2 of a fetch.
  - Cycle 3: all outputs are 0 and no `if_done` pulse occurs.
  - With `if_req` still high, the fetch is reissued with `mem_en`=1 at cycle 4.
- LAT=1 corner:
  - Back-to-back data reads issue at cycles 1 and 4, with `d_done` at cycles 2 and 5.
